// File: rtl/mips_defs_pkg.sv
// Shared MIPS pipeline definitions: multiply/divide op encodings and unit state type.
package mips_defs;

    localparam int MD_OP_W = 3;

    localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
    localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
    localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
    localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
    localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
    localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
    localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;
    localparam logic [MD_OP_W-1:0] MD_RESV  = 3'd7;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_RUN  = 1'b1
    } md_state_e;

    // Ops that occupy the unit for a multi-cycle countdown.
    function automatic logic md_is_arith(input logic [MD_OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic md_is_div(input logic [MD_OP_W-1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational 64-bit result for MULT/MULTU/DIV/DIVU, with a divide-by-zero flag.
module md_arith
    import mips_defs::*;
(
    input  logic [MD_OP_W-1:0] op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    output logic [31:0]        res_hi,
    output logic [31:0]        res_lo,
    output logic               div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        is_signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quot_mag;
    logic [31:0] rem_mag;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // One unsigned divider serves both forms: DIV divides magnitudes and fixes signs
    // afterwards, which also makes 0x80000000 / -1 wrap to 0x80000000 without a trap.
    assign is_signed_div = (op == MD_DIV);
    assign div_by_zero   = md_is_div(op) && (b == 32'd0);
    assign dividend      = (is_signed_div && a[31]) ? (32'd0 - a) : a;
    assign divisor       = div_by_zero ? 32'd1
                         : ((is_signed_div && b[31]) ? (32'd0 - b) : b);
    assign quot_mag      = dividend / divisor;
    assign rem_mag       = dividend % divisor;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            MD_MULT:  {res_hi, res_lo} = prod_s;
            MD_MULTU: {res_hi, res_lo} = prod_u;
            MD_DIV: begin
                res_lo = (a[31] ^ b[31]) ? (32'd0 - quot_mag) : quot_mag;
                res_hi = a[31] ? (32'd0 - rem_mag) : rem_mag;
            end
            MD_DIVU: begin
                res_lo = quot_mag;
                res_hi = rem_mag;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/e_md_unit.sv
// Execute-stage multiply/divide unit: architectural HI/LO, fixed-latency MULT/DIV, one-cycle MTHI/MTLO.
module e_md_unit
    import mips_defs::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [MD_OP_W-1:0] md_op,
    input  logic [31:0]        a,
    input  logic [31:0]        b,
    output logic               busy,
    output logic [31:0]        hi,
    output logic [31:0]        lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    md_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       pend_hi_q, pend_hi_d;
    logic [31:0]       pend_lo_q, pend_lo_d;
    logic              pend_dz_q, pend_dz_d;

    logic [31:0]       arith_hi;
    logic [31:0]       arith_lo;
    logic              arith_dz;

    md_arith u_arith (
        .op          (md_op),
        .a           (a),
        .b           (b),
        .res_hi      (arith_hi),
        .res_lo      (arith_lo),
        .div_by_zero (arith_dz)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_dz_d = pend_dz_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    if (md_is_arith(md_op)) begin
                        // Result is captured at issue so operands need not be held while counting.
                        pend_hi_d = arith_hi;
                        pend_lo_d = arith_lo;
                        pend_dz_d = arith_dz;
                        cnt_d     = md_is_div(md_op) ? CNT_W'(DIV_CYCLES - 1)
                                                     : CNT_W'(MULT_CYCLES - 1);
                        state_d   = MD_RUN;
                    end else if (md_op == MD_MTHI) begin
                        hi_d = a;
                    end else if (md_op == MD_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            MD_RUN: begin
                if (cnt_q == '0) begin
                    if (!pend_dz_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    state_d = MD_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MD_IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_dz_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_dz_q <= pend_dz_d;
        end
    end

    assign busy = (state_q == MD_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_e_md_unit.sv
// Self-checking bench for e_md_unit: directed cases plus randomized ops against an arithmetic model.
module tb_e_md_unit;
    import mips_defs::*;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    e_md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .md_op (md_op),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Architectural effect of one op on {HI,LO}, from the instruction definitions.
    task automatic model(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] eh, output logic [31:0] el, output int n);
        longint sa, sb, q, r;
        logic [63:0] p;
        eh = m_hi;
        el = m_lo;
        n  = 0;
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        case (op)
            3'd1: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; n = MULT_N; end
            3'd2: begin p = {32'd0, av} * {32'd0, bv}; eh = p[63:32]; el = p[31:0]; n = MULT_N; end
            3'd3: begin
                n = DIV_N;
                if (bv != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    el = q[31:0];
                    eh = r[31:0];
                end
            end
            3'd4: begin
                n = DIV_N;
                if (bv != 0) begin el = av / bv; eh = av % bv; end
            end
            3'd5: eh = av;
            3'd6: el = av;
            default: ;
        endcase
    endtask

    // Issues one op at the current negedge and follows it to completion; ends on a negedge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        logic [31:0] eh, el;
        int n, cnt;
        logic early;
        model(op, av, bv, eh, el, n);
        start = 1'b1; md_op = op; a = av; b = bv;
        @(posedge clk);
        #1;
        start = 1'b0; md_op = 3'($urandom); a = $urandom; b = $urandom;
        cnt = 0;
        early = 1'b0;
        @(negedge clk);
        while (busy === 1'b1 && cnt < n + 4) begin
            if (hi !== m_hi || lo !== m_lo) early = 1'b1;
            cnt++;
            @(negedge clk);
        end
        n_tests++;
        if (cnt != n) begin
            n_fail++;
            $display("[TB] FAIL busy_len op=%0d got=%0d exp=%0d", op, cnt, n);
        end
        n_tests++;
        if (early) begin
            n_fail++;
            $display("[TB] FAIL early_writeback op=%0d got=1 exp=0", op);
        end
        n_tests++;
        if (busy !== 1'b0 || hi !== eh || lo !== el) begin
            n_fail++;
            $display("[TB] FAIL result op=%0d a=%h b=%h got busy=%b hi=%h lo=%h exp busy=0 hi=%h lo=%h",
                     op, av, bv, busy, hi, lo, eh, el);
        end
        m_hi = eh;
        m_lo = el;
        $display("[TB] op=%0d a=%h b=%h busy_cycles=%0d hi=%h lo=%h", op, av, bv, cnt, hi, lo);
    endtask

    task automatic check_const(input string name, input logic [31:0] got_hi, input logic [31:0] got_lo,
                               input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        n_tests++;
        if (got_hi !== exp_hi || got_lo !== exp_lo) begin
            n_fail++;
            $display("[TB] FAIL %s got hi=%h lo=%h exp hi=%h lo=%h", name, got_hi, got_lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; md_op = MD_MULT; a = 32'd7; b = 32'd9;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state got busy=%b hi=%h lo=%h exp busy=0 hi=0 lo=0", busy, hi, lo);
        end
        reset = 1'b0; start = 1'b0; md_op = MD_NONE;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_release got busy=%b hi=%h lo=%h exp busy=0 hi=0 lo=0", busy, hi, lo);
        end
        $display("[TB] reset busy=%b hi=%h lo=%h", busy, hi, lo);
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic test_mult();
        run_op(MD_MULT, 32'hFFFFFFFD, 32'd5);
        check_const("mult_neg", hi, lo, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check_const("multu_max", hi, lo, 32'hFFFFFFFE, 32'h00000001);
        run_op(MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF);
        check_const("mult_m1sq", hi, lo, 32'h00000000, 32'h00000001);
    endtask

    task automatic test_div();
        run_op(MD_DIV, 32'hFFFFFFF9, 32'd2);
        check_const("div_neg", hi, lo, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op(MD_DIV, 32'h80000000, 32'hFFFFFFFF);
        check_const("div_ovf", hi, lo, 32'h00000000, 32'h80000000);
        run_op(MD_DIVU, 32'd7, 32'd0);
        check_const("divu_zero", hi, lo, 32'h00000000, 32'h80000000);
        run_op(MD_DIVU, 32'hFFFFFFF9, 32'd2);
        check_const("divu_big", hi, lo, 32'h00000001, 32'h7FFFFFFC);
    endtask

    task automatic test_ignore_during_busy();
        int cnt;
        logic [31:0] eh, el;
        int n;
        model(MD_MULT, 32'd1000, 32'd3, eh, el, n);
        start = 1'b1; md_op = MD_MULT; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1; start = 1'b0;
        @(negedge clk);                      // busy cycle 1
        @(negedge clk);                      // busy cycle 2
        start = 1'b1; md_op = MD_MTHI; a = 32'h1234;
        @(posedge clk); #1; start = 1'b0; md_op = MD_NONE;
        cnt = 2;
        @(negedge clk);
        while (busy === 1'b1 && cnt < MULT_N + 4) begin
            cnt++;
            @(negedge clk);
        end
        n_tests++;
        if (cnt != MULT_N || hi !== eh || lo !== el) begin
            n_fail++;
            $display("[TB] FAIL ignore_busy got cycles=%0d hi=%h lo=%h exp cycles=%0d hi=%h lo=%h",
                     cnt, hi, lo, MULT_N, eh, el);
        end
        m_hi = eh;
        m_lo = el;
        $display("[TB] mult with ignored mthi busy_cycles=%0d hi=%h lo=%h", cnt, hi, lo);
        run_op(MD_MTHI, 32'h1234, 32'd0);
        check_const("mthi", hi, lo, 32'h00001234, el);
        run_op(MD_MTLO, 32'hCAFEF00D, 32'd0);
        check_const("mtlo", hi, lo, 32'h00001234, 32'hCAFEF00D);
    endtask

    task automatic test_reset_mid_op();
        logic bad;
        start = 1'b1; md_op = MD_DIV; a = 32'd100; b = 32'd7;
        @(posedge clk); #1; start = 1'b0; md_op = MD_NONE;
        repeat (3) @(negedge clk);           // now in busy cycle 3
        reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid got busy=%b hi=%h lo=%h exp busy=0 hi=0 lo=0", busy, hi, lo);
        end
        bad = 1'b0;
        for (int i = 0; i < DIV_N + 2; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad = 1'b1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("[TB] FAIL late_writeback got=1 exp=0");
        end
        m_hi = 32'd0;
        m_lo = 32'd0;
        $display("[TB] reset mid-div busy=%b hi=%h lo=%h", busy, hi, lo);
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] av, bv;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            av = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            bv = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) bv = 32'($urandom_range(1, 9));
            run_op(op, av, bv);            // issued back-to-back on the first idle cycle
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; md_op = MD_NONE; a = 32'd0; b = 32'd0;
        @(negedge clk);
        test_reset();
        test_mult();
        test_div();
        test_ignore_during_busy();
        test_reset_mid_op();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
